// File: rtl/moore_detector_scheduler.sv
// Round-robin front end that time-shares one serial Moore detector.
// Each granted word is shifted in LSB-first and its MATCH_STATE samples counted.
module moore_detector_scheduler #(
  parameter int         N_REQ       = 4,
  parameter int         ID_W        = 2,
  parameter int         WIDTH       = 8,
  parameter int         CNT_W       = 4,
  parameter logic [1:0] MATCH_STATE = 2'b11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       grant,
  output logic                   x_out,
  output logic                   det_rst_n,
  input  logic [1:0]             y_in,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       match_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               x_q, x_d;
  logic               drst_q, drst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;

  logic [2*N_REQ-1:0] rr;
  logic [N_REQ-1:0]   rot;
  logic               any_req;
  logic [ID_W:0]      win_w;
  logic [ID_W:0]      nxt_w;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    nxt;
  logic [WIDTH-1:0]   word;
  logic [N_REQ-1:0]   onehot;
  logic               hit;

  // Rotate requests so bit 0 is the pointer; lowest set bit wins.
  always_comb begin
    rr      = {req, req} >> ptr_q;
    rot     = rr[N_REQ-1:0];
    any_req = 1'b0;
    win_w   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (rot[off]) begin
        any_req = 1'b1;
        win_w   = {1'b0, ptr_q} + (ID_W+1)'(off);
      end
    end
    if (win_w >= (ID_W+1)'(N_REQ)) begin
      win_w = win_w - (ID_W+1)'(N_REQ);
    end
    win   = win_w[ID_W-1:0];
    nxt_w = win_w + (ID_W+1)'(1);
    if (nxt_w >= (ID_W+1)'(N_REQ)) begin
      nxt_w = '0;
    end
    nxt = nxt_w[ID_W-1:0];
  end

  always_comb begin
    word   = '0;
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) begin
        word      = data[k*WIDTH +: WIDTH];
        onehot[k] = 1'b1;
      end
    end
  end

  assign hit = (y_in == MATCH_STATE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    x_d       = x_q;
    drst_d    = drst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    mcnt_d    = mcnt_q;
    unique case (state_q)
      S_IDLE: begin
        drst_d = 1'b1;
        x_d    = 1'b0;
        if (any_req) begin
          sh_d    = word;
          id_d    = win;
          grant_d = onehot;
          drst_d  = 1'b0;
          busy_d  = 1'b1;
          ptr_d   = nxt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        drst_d  = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
        x_d     = sh_q[0];
        sh_d    = sh_q >> 1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // y_in in cycle 0 is the cleared state, not a bit result
        if (bit_q != '0 && hit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (bit_q == CNT_W'(WIDTH - 1)) begin
          x_d     = 1'b0;
          state_d = S_DRAIN;
        end else begin
          x_d   = sh_q[0];
          sh_d  = sh_q >> 1;
          bit_d = bit_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        mcnt_d    = cnt_q + CNT_W'(hit);
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      x_q       <= 1'b0;
      drst_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      x_q       <= x_d;
      drst_q    <= drst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign grant       = grant_q;
  assign x_out       = x_q;
  assign det_rst_n   = drst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign match_count = mcnt_q;

endmodule

// File: doc/moore_detector_scheduler.md
Name: moore_detector_scheduler

Overview:
- Round-robin scheduler that shares one serial Moore sequence detector (2-bit state output, detector reset asynchronous active-low) among N_REQ requesters.
- Grants one requester at a time and captures its WIDTH-bit word.
- Clears the detector, shifts the word into it LSB-first, counts the cycles in which the detector state equals MATCH_STATE, and reports the count with the requester ID.
- Sits between the requesting blocks and the detector instance; the detector's x_in, reset and y_out connect to x_out, det_rst_n and y_in.

Parameters:
- N_REQ, 4, number of requesters (2..2^ID_W).
- ID_W, 2, width of the requester index.
- WIDTH, 8, bits per frame (>=2).
- CNT_W, 4, width of match_count; must satisfy 2^CNT_W > WIDTH.
- MATCH_STATE, 2'b11, detector state value that is counted.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level.
- data  input  N_REQ*WIDTH  requester k word at bits [k*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot, one-cycle acknowledge; the word is captured on that cycle's entry edge.
- x_out  output  1  serial bit to the detector.
- det_rst_n  output  1  registered active-low clear to the detector.
- y_in  input  2  detector state output.
- busy  output  1  high from LOAD through DONE.
- done  output  1  one-cycle result strobe.
- done_id  output  ID_W  index of the requester whose frame finished.
- match_count  output  CNT_W  number of MATCH_STATE samples in the last frame.

Behaviour:
- Clock and reset are fixed: one clock, named clock; reset is asynchronous and active-low, named reset.
- All outputs are registered.
- Reset (reset=0, asynchronous) values:
  - state=IDLE, rr pointer=0, grant=0, x_out=0, busy=0, done=0, done_id=0, match_count=0.
  - det_rst_n=0: the detector is held cleared while the scheduler is in reset.
- IDLE:
  - det_rst_n=1, x_out=0.
  - If any req is high, pick the first set req scanning from the pointer upward, wrapping modulo N_REQ.
  - At the edge: capture data of the winner into the shift register, store its ID, set grant bit, det_rst_n<=0, busy<=1, pointer<=(winner+1) mod N_REQ, go to LOAD.
  - No req: stay in IDLE; the pointer is unchanged.
- LOAD (1 cycle):
  - grant is high for exactly this cycle; det_rst_n=0 clears the detector to state 00.
  - Clear the counter; go to SHIFT.
- SHIFT (WIDTH cycles, index i=0..WIDTH-1):
  - x_out = bit i of the captured word; det_rst_n=1; grant=0.
  - In cycles i>=1, sample y_in at the ending edge; increment the counter if y_in==MATCH_STATE.
  - After i=WIDTH-1, go to DRAIN.
- DRAIN (1 cycle):
  - x_out=0; sample y_in, which carries the state after the last bit, and count it.
  - At the edge: match_count<=final count, done_id<=stored ID, done<=1; go to DONE.
- DONE (1 cycle):
  - done=1, busy=1; go to IDLE. done drops and busy drops on exit.
- Totals per frame:
  - Exactly WIDTH samples are counted.
  - Grant cycle to done cycle spacing is WIDTH+2 cycles.
  - Minimum frame period is WIDTH+4 cycles, including one IDLE cycle.
- match_count and done_id hold their values until the next DONE.
- Handshake: requesters must hold req and data stable until they see grant. Dropping req before grant is a legal withdrawal. req is ignored outside IDLE. A requester re-asserting immediately after its grant loses to any other pending requester (round-robin fairness).
- Simultaneous requests: exactly one grant per frame; no requester waits more than N_REQ-1 frames.
- Counter cannot overflow given the CNT_W constraint.
- Reset mid-frame: returns immediately to reset values; the partial frame is discarded with no done; the detector is cleared via det_rst_n=0.

Test Plan:
- Reset, then single req[0] with data 8'h0F → grant=0001 for one cycle; x_out sequence 1,1,1,1,0,0,0,0; done 10 cycles after grant; done_id=0, match_count=2.
- req[2] with data 8'hFF → done_id=2, match_count=6; data 8'h00 → match_count=0; data 8'h77 → match_count=2.
- All four req high continuously, data all 8'hFF → grants in order 0,1,2,3,0; each frame 12 cycles apart; every done has match_count=6 with matching done_id.
- req[1] asserted, then dropped before IDLE, while req[3] is high → only req[3] granted; pointer becomes 0.
- Assert reset=0 during SHIFT cycle 4 → all outputs return to reset values asynchronously; no done. After release, a pending req is re-granted starting from pointer 0.
- Check det_rst_n=0 exactly in the LOAD cycle of each frame: the detector state reads 00 in SHIFT cycle 0, even after a frame that ended in state 11.
